// File: rtl/tdm_demux_4.sv
// 4-slot time-division demultiplexer: steers a serial word stream (slot 0 marked by sof)
// into four parallel outputs that update together once a complete frame has arrived.
module tdm_demux_4 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         sof,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [W-1:0] y3,
    output logic [1:0]   slot,
    output logic         locked,
    output logic         frame_done,
    output logic         sync_err
);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t       state;
    logic [W-1:0] sh0;
    logic [W-1:0] sh1;
    logic [W-1:0] sh2;

    assign locked = (state == LOCKED);

    // Frame alignment FSM, shadow capture and whole-frame output transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            slot       <= 2'd0;
            sh0        <= '0;
            sh1        <= '0;
            sh2        <= '0;
            y0         <= '0;
            y1         <= '0;
            y2         <= '0;
            y3         <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            if (din_valid) begin
                case (state)
                    HUNT: begin
                        if (sof) begin
                            sh0   <= din;
                            slot  <= 2'd1;
                            state <= LOCKED;
                        end else begin
                            slot  <= 2'd0;
                        end
                    end
                    LOCKED: begin
                        if (slot == 2'd0) begin
                            if (sof) begin
                                sh0  <= din;
                                slot <= 2'd1;
                            end else begin
                                sync_err <= 1'b1;
                                slot     <= 2'd0;
                                state    <= HUNT;
                            end
                        end else if (sof) begin
                            // Early sof: drop the partial frame and restart on this word
                            sync_err <= 1'b1;
                            sh0      <= din;
                            slot     <= 2'd1;
                        end else begin
                            case (slot)
                                2'd1: begin
                                    sh1  <= din;
                                    slot <= 2'd2;
                                end
                                2'd2: begin
                                    sh2  <= din;
                                    slot <= 2'd3;
                                end
                                2'd3: begin
                                    y0         <= sh0;
                                    y1         <= sh1;
                                    y2         <= sh2;
                                    y3         <= din;
                                    slot       <= 2'd0;
                                    frame_done <= 1'b1;
                                end
                                default: begin
                                    slot <= 2'd0;
                                end
                            endcase
                        end
                    end
                    default: begin
                        state <= HUNT;
                        slot  <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_4.sv
// Scoreboard bench for tdm_demux_4: stimulus pushes expected frame/error events,
// a negedge monitor pops and compares them whenever the DUT pulses frame_done or sync_err.
module tb_tdm_demux_4;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       sof;
    logic [7:0] y0, y1, y2, y3;
    logic [1:0] slot;
    logic       locked, frame_done, sync_err;

    typedef struct packed {
        logic       err;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] e3;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] cur_y [4];
    int         tests = 0;
    int         fails = 0;

    tdm_demux_4 #(.W(8)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .slot(slot), .locked(locked),
        .frame_done(frame_done), .sync_err(sync_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic s, input logic [7:0] d);
        @(negedge clk);
        din       = d;
        sof       = s;
        din_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din_valid = 1'b0;
            sof       = 1'b0;
            din       = 8'h00;
        end
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        ev_t e;
        e.err = 1'b0; e.e0 = a; e.e1 = b; e.e2 = c; e.e3 = d;
        exp_q.push_back(e);
        cur_y[0] = a; cur_y[1] = b; cur_y[2] = c; cur_y[3] = d;
    endtask

    task automatic push_err();
        ev_t e;
        e.err = 1'b1; e.e0 = cur_y[0]; e.e1 = cur_y[1]; e.e2 = cur_y[2]; e.e3 = cur_y[3];
        exp_q.push_back(e);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        push_frame(a, b, c, d);
        send(1'b1, a);
        send(1'b0, b);
        send(1'b0, c);
        send(1'b0, d);
    endtask

    task automatic check_y(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        check({name, ".y0"}, int'(y0), int'(a));
        check({name, ".y1"}, int'(y1), int'(b));
        check({name, ".y2"}, int'(y2), int'(c));
        check({name, ".y3"}, int'(y3), int'(d));
    endtask

    // Monitor: every frame_done / sync_err pulse must match the oldest expected event
    always @(negedge clk) begin
        if (!rst && (frame_done || sync_err)) begin
            ev_t e;
            check("pulse_exclusive", int'(frame_done && sync_err), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, sync_err, frame_done}, 0);
            end else begin
                e = exp_q.pop_front();
                check("event_kind_err", int'(sync_err), int'(e.err));
                check("ev.y0", int'(y0), int'(e.e0));
                check("ev.y1", int'(y1), int'(e.e1));
                check("ev.y2", int'(y2), int'(e.e2));
                check("ev.y3", int'(y3), int'(e.e3));
            end
        end
    end

    initial begin
        rst = 1'b1; din = 8'h00; din_valid = 1'b0; sof = 1'b0;
        for (int i = 0; i < 4; i++) cur_y[i] = 8'h00;
        #1;
        check_y("reset", 8'h00, 8'h00, 8'h00, 8'h00);
        check("reset.slot", int'(slot), 0);
        check("reset.locked", int'(locked), 0);
        check("reset.fd", int'(frame_done), 0);
        check("reset.se", int'(sync_err), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // 1: single frame
        frame(8'h11, 8'h22, 8'h33, 8'h44);
        idle(1);
        check_y("t1", 8'h11, 8'h22, 8'h33, 8'h44);
        check("t1.slot", int'(slot), 0);
        check("t1.locked", int'(locked), 1);
        idle(1);
        check("t1.fd_cleared", int'(frame_done), 0);

        // 2: back-to-back frames with gaps inside the second
        frame(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        push_frame(8'h01, 8'h02, 8'h03, 8'h04);
        send(1'b1, 8'h01);
        send(1'b0, 8'h02);
        idle(3);
        check("t2.slot_gap", int'(slot), 2);
        check_y("t2.hold", 8'hAA, 8'hBB, 8'hCC, 8'hDD);
        send(1'b0, 8'h03);
        idle(3);
        check("t2.slot_gap2", int'(slot), 3);
        check_y("t2.hold2", 8'hAA, 8'hBB, 8'hCC, 8'hDD);
        send(1'b0, 8'h04);
        idle(1);
        check_y("t2", 8'h01, 8'h02, 8'h03, 8'h04);

        // 3: hunt drops non-sof words silently
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 4; i++) cur_y[i] = 8'h00;
        @(negedge clk); rst = 1'b0;
        send(1'b0, 8'h55);
        send(1'b0, 8'h66);
        idle(1);
        check("t3.hunt_locked", int'(locked), 0);
        check("t3.hunt_slot", int'(slot), 0);
        push_frame(8'h10, 8'h20, 8'h30, 8'h40);
        send(1'b1, 8'h10);
        idle(1);
        check("t3.locked", int'(locked), 1);
        send(1'b0, 8'h20);
        send(1'b0, 8'h30);
        send(1'b0, 8'h40);
        idle(1);
        check_y("t3", 8'h10, 8'h20, 8'h30, 8'h40);

        // 4: early sof restarts the frame
        send(1'b1, 8'h01);
        send(1'b0, 8'h02);
        push_err();
        push_frame(8'h0A, 8'h0B, 8'h0C, 8'h0D);
        send(1'b1, 8'h0A);
        idle(1);
        check("t4.slot", int'(slot), 1);
        check("t4.locked", int'(locked), 1);
        send(1'b0, 8'h0B);
        send(1'b0, 8'h0C);
        send(1'b0, 8'h0D);
        idle(1);
        check_y("t4", 8'h0A, 8'h0B, 8'h0C, 8'h0D);

        // 5: missing sof at slot 0 drops lock
        frame(8'h01, 8'h02, 8'h03, 8'h04);
        push_err();
        send(1'b0, 8'h99);
        idle(1);
        check("t5.locked", int'(locked), 0);
        check_y("t5", 8'h01, 8'h02, 8'h03, 8'h04);
        frame(8'h01, 8'h02, 8'h03, 8'h04);
        idle(1);
        check("t5.relock", int'(locked), 1);

        // 6: asynchronous reset mid-frame
        send(1'b1, 8'h05);
        send(1'b0, 8'h06);
        @(posedge clk);
        #2 rst = 1'b1;
        din_valid = 1'b0;
        #1;
        check_y("t6.async", 8'h00, 8'h00, 8'h00, 8'h00);
        check("t6.slot", int'(slot), 0);
        check("t6.locked", int'(locked), 0);
        for (int i = 0; i < 4; i++) cur_y[i] = 8'h00;
        @(negedge clk); rst = 1'b0;
        frame(8'h09, 8'h0A, 8'h0B, 8'h0C);
        idle(2);
        check_y("t6", 8'h09, 8'h0A, 8'h0B, 8'h0C);
        check("t6.slot_end", int'(slot), 0);

        idle(2);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
